// File: rtl/lsu_pkg.sv
// Shared encodings, FSM state type and decode helpers for the load/store unit.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE_HI = 2'd1,
        ST_WAIT     = 2'd2
    } lsu_state_e;

    function automatic logic [2:0] size_bytes(input logic [2:0] f3);
        logic [2:0] sz;
        case (f3[1:0])
            2'b00:   sz = 3'd1;
            2'b01:   sz = 3'd2;
            default: sz = 3'd4;
        endcase
        return sz;
    endfunction

    function automatic logic [3:0] size_mask(input logic [2:0] f3);
        logic [3:0] m;
        case (f3[1:0])
            2'b00:   m = 4'b0001;
            2'b01:   m = 4'b0011;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    // Stores only have the signed-width encodings; loads add the unsigned ones.
    function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
        logic ok;
        case (f3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = !is_store;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic lat_legal(input int lat);
        return (lat == 1) || (lat == 2);
    endfunction

endpackage

// File: rtl/lsu_load_fmt.sv
// Combinational load formatter: aligns the {hi,lo} word pair by the byte offset
// and sign/zero-extends according to funct3.
module lsu_load_fmt
    import lsu_pkg::*;
(
    input  logic [31:0] hi_i,
    input  logic [31:0] lo_i,
    input  logic [1:0]  off_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [31:0] sh_s;

    assign sh_s = 32'({hi_i, lo_i} >> {off_i, 3'b000});

    // Byte/half/word select with extension
    always_comb begin
        data_o = 32'h0000_0000;
        case (funct3_i)
            F3_B:    data_o = {{24{sh_s[7]}}, sh_s[7:0]};
            F3_H:    data_o = {{16{sh_s[15]}}, sh_s[15:0]};
            F3_W:    data_o = sh_s;
            F3_BU:   data_o = {24'h00_0000, sh_s[7:0]};
            F3_HU:   data_o = {16'h0000, sh_s[15:0]};
            default: data_o = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/lsu_bram.sv
// Load/store unit in front of a synchronous-read data BRAM. Word-crossing
// accesses are split into a lo and a hi word access; ReqReady low stalls the core.
module lsu_bram
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int LAT    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ReqValid,
    output logic              ReqReady,
    input  logic              MemWriteM,
    input  logic [2:0]        Funct3M,
    input  logic [ADDR_W-1:0] AddrM,
    input  logic [31:0]       WriteDataM,
    input  logic              Flush,
    output logic              RspValid,
    output logic [31:0]       RspData,
    output logic              RspErr,
    output logic              BramEn,
    output logic [3:0]        BramWe,
    output logic [ADDR_W-3:0] BramAddr,
    output logic [31:0]       BramWData,
    input  logic [31:0]       BramRData
);

    localparam int         WA_W   = ADDR_W - 2;
    localparam logic [1:0] LAT_LO = 2'(LAT);
    localparam logic [1:0] LAT_HI = 2'(LAT + 1);

    if (!lat_legal(LAT)) begin : g_lat_illegal
        $error("lsu_bram: LAT must be 1 or 2");
    end

    lsu_state_e      state_q, state_d;
    logic [1:0]      cnt_q, cnt_d;
    logic [WA_W-1:0] addr_q, addr_d;
    logic [1:0]      off_q, off_d;
    logic [2:0]      f3_q, f3_d;
    logic            mis_q, mis_d;
    logic            store_q, store_d;
    logic            kill_q, kill_d;
    logic [31:0]     wdata_hi_q, wdata_hi_d;
    logic [3:0]      we_hi_q, we_hi_d;
    logic [31:0]     hold_q, hold_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic            rsp_err_q, rsp_err_d;
    logic [31:0]     rsp_data_q, rsp_data_d;

    logic [1:0]      off_s;
    logic [2:0]      size_s;
    logic            legal_s, mis_s, accept_s, done_s;
    logic [63:0]     lane_s;
    logic [7:0]      mask_s;
    logic            bram_en_s;
    logic [3:0]      bram_we_s;
    logic [WA_W-1:0] bram_addr_s;
    logic [31:0]     bram_wdata_s;
    logic [31:0]     fmt_lo_s, fmt_hi_s, fmt_data_s;

    assign off_s    = AddrM[1:0];
    assign size_s   = size_bytes(Funct3M);
    assign legal_s  = f3_legal(MemWriteM, Funct3M);
    assign mis_s    = ({2'b00, off_s} + {1'b0, size_s}) > 4'd4;
    assign lane_s   = {32'h0000_0000, WriteDataM} << {off_s, 3'b000};
    assign mask_s   = {4'h0, size_mask(Funct3M)} << off_s;
    assign ReqReady = (state_q == ST_IDLE) && !reset;
    assign accept_s = ReqValid && ReqReady && !Flush;

    // cnt_q counts cycles since the lo access; the last needed word arrives at LAT (+1 if split).
    assign done_s   = (cnt_q == (mis_q ? LAT_HI : LAT_LO));
    assign fmt_lo_s = mis_q ? hold_q : BramRData;
    assign fmt_hi_s = mis_q ? BramRData : 32'h0000_0000;

    lsu_load_fmt u_fmt (
        .hi_i     (fmt_hi_s),
        .lo_i     (fmt_lo_s),
        .off_i    (off_q),
        .funct3_i (f3_q),
        .data_o   (fmt_data_s)
    );

    // Next-state, BRAM port drive and response formation
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        off_d        = off_q;
        f3_d         = f3_q;
        mis_d        = mis_q;
        store_d      = store_q;
        kill_d       = kill_q;
        wdata_hi_d   = wdata_hi_q;
        we_hi_d      = we_hi_q;
        hold_d       = hold_q;
        rsp_valid_d  = 1'b0;
        rsp_err_d    = 1'b0;
        rsp_data_d   = 32'h0000_0000;
        bram_en_s    = 1'b0;
        bram_we_s    = 4'b0000;
        bram_addr_s  = '0;
        bram_wdata_s = 32'h0000_0000;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    addr_d     = AddrM[ADDR_W-1:2];
                    off_d      = off_s;
                    f3_d       = Funct3M;
                    mis_d      = mis_s;
                    store_d    = MemWriteM;
                    wdata_hi_d = lane_s[63:32];
                    we_hi_d    = mask_s[7:4];
                    kill_d     = 1'b0;
                    cnt_d      = 2'd1;
                    if (!legal_s) begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else begin
                        bram_en_s    = 1'b1;
                        bram_addr_s  = AddrM[ADDR_W-1:2];
                        bram_we_s    = MemWriteM ? mask_s[3:0] : 4'b0000;
                        bram_wdata_s = MemWriteM ? lane_s[31:0] : 32'h0000_0000;
                        if (mis_s) begin
                            state_d = ST_ISSUE_HI;
                        end else if (!MemWriteM) begin
                            state_d = ST_WAIT;
                        end else begin
                            rsp_valid_d = 1'b1;
                        end
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE_HI: begin
                bram_en_s   = 1'b1;
                bram_addr_s = addr_q + {{(WA_W-1){1'b0}}, 1'b1};
                cnt_d       = cnt_q + 2'd1;
                if (store_q) begin
                    bram_we_s    = we_hi_q;
                    bram_wdata_s = wdata_hi_q;
                    rsp_valid_d  = 1'b1;
                    state_d      = ST_IDLE;
                end else begin
                    hold_d  = (cnt_q == LAT_LO) ? BramRData : hold_q;
                    kill_d  = kill_q || Flush;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d  = cnt_q + 2'd1;
                kill_d = kill_q || Flush;
                hold_d = (cnt_q == LAT_LO) ? BramRData : hold_q;
                if (done_s) begin
                    rsp_valid_d = !(kill_q || Flush);
                    rsp_data_d  = (kill_q || Flush) ? 32'h0000_0000 : fmt_data_s;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Reset forces the port quiet immediately, independent of the clock
    assign BramEn    = bram_en_s && !reset;
    assign BramWe    = reset ? 4'b0000 : bram_we_s;
    assign BramAddr  = reset ? '0 : bram_addr_s;
    assign BramWData = reset ? 32'h0000_0000 : bram_wdata_s;

    assign RspValid = rsp_valid_q;
    assign RspData  = rsp_data_q;
    assign RspErr   = rsp_err_q;

    // Control, request and response registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 2'd0;
            addr_q      <= '0;
            off_q       <= 2'd0;
            f3_q        <= 3'd0;
            mis_q       <= 1'b0;
            store_q     <= 1'b0;
            kill_q      <= 1'b0;
            wdata_hi_q  <= 32'h0000_0000;
            we_hi_q     <= 4'b0000;
            hold_q      <= 32'h0000_0000;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= 32'h0000_0000;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            off_q       <= off_d;
            f3_q        <= f3_d;
            mis_q       <= mis_d;
            store_q     <= store_d;
            kill_q      <= kill_d;
            wdata_hi_q  <= wdata_hi_d;
            we_hi_q     <= we_hi_d;
            hold_q      <= hold_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

endmodule

// File: tb/tb_lsu_bram.sv
// Directed bench: one lsu_bram with LAT=1 and one with LAT=2 share the request
// inputs, each with its own behavioural BRAM.
module tb_lsu_bram;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        ReqValid, MemWriteM, Flush;
    logic [2:0]  Funct3M;
    logic [11:0] AddrM;
    logic [31:0] WriteDataM;

    logic        rdy1, rv1, re1, en1, rdy2, rv2, re2, en2;
    logic [31:0] rd1, bw1, rdat1, rd2, bw2, rdat2;
    logic [3:0]  we1, we2;
    logic [9:0]  ba1, ba2;

    logic [31:0] mem1 [0:1023];
    logic [31:0] mem2 [0:1023];
    logic [31:0] r1_q, p2_q, r2_q;
    logic        pl_en;
    logic [9:0]  pl_a;
    logic [31:0] pl_d;

    int n_chk, n_pass;

    logic        en_log1 [0:7];
    logic [3:0]  we_log1 [0:7];
    logic [9:0]  ad_log1 [0:7];
    logic [31:0] wd_log1 [0:7];
    logic        en_log2 [0:7];
    logic [9:0]  ad_log2 [0:7];

    always #5 clk = ~clk;

    lsu_bram #(.ADDR_W(12), .LAT(1)) u_lat1 (
        .clk(clk), .reset(reset), .ReqValid(ReqValid), .ReqReady(rdy1),
        .MemWriteM(MemWriteM), .Funct3M(Funct3M), .AddrM(AddrM), .WriteDataM(WriteDataM),
        .Flush(Flush), .RspValid(rv1), .RspData(rd1), .RspErr(re1),
        .BramEn(en1), .BramWe(we1), .BramAddr(ba1), .BramWData(bw1), .BramRData(rdat1)
    );

    lsu_bram #(.ADDR_W(12), .LAT(2)) u_lat2 (
        .clk(clk), .reset(reset), .ReqValid(ReqValid), .ReqReady(rdy2),
        .MemWriteM(MemWriteM), .Funct3M(Funct3M), .AddrM(AddrM), .WriteDataM(WriteDataM),
        .Flush(Flush), .RspValid(rv2), .RspData(rd2), .RspErr(re2),
        .BramEn(en2), .BramWe(we2), .BramAddr(ba2), .BramWData(bw2), .BramRData(rdat2)
    );

    assign rdat1 = r1_q;
    assign rdat2 = r2_q;

    always @(posedge clk) begin
        r2_q <= p2_q;
        if (pl_en) begin
            mem1[pl_a] <= pl_d;
            mem2[pl_a] <= pl_d;
        end else begin
            if (en1) begin
                if (we1 != 4'b0000) begin
                    for (int b = 0; b < 4; b++)
                        if (we1[b]) mem1[ba1][8*b +: 8] <= bw1[8*b +: 8];
                end else begin
                    r1_q <= mem1[ba1];
                end
            end
            if (en2) begin
                if (we2 != 4'b0000) begin
                    for (int b = 0; b < 4; b++)
                        if (we2[b]) mem2[ba2][8*b +: 8] <= bw2[8*b +: 8];
                end else begin
                    p2_q <= mem2[ba2];
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic pl(input logic [9:0] a, input logic [31:0] d);
        pl_en = 1'b1;
        pl_a  = a;
        pl_d  = d;
        tick();
        pl_en = 1'b0;
    endtask

    task automatic snap(input int c);
        en_log1[c] = en1;
        we_log1[c] = we1;
        ad_log1[c] = ba1;
        wd_log1[c] = bw1;
        en_log2[c] = en2;
        ad_log2[c] = ba2;
    endtask

    // One request at cycle 0, observed for 7 cycles; er = cycle ReqReady returns
    // high (also the response cycle when ev is set), fl_at = cycle Flush is raised.
    task automatic xact(input string tag, input logic w, input logic [2:0] f3,
                        input logic [11:0] a, input logic [31:0] wd, input int fl_at,
                        input int er1, input logic ev1, input int er2, input logic ev2,
                        input logic [31:0] ed, input logic ee);
        int          rr1, rr2, rl1, rl2;
        logic [31:0] d1, d2;
        logic        e1, e2;
        rr1 = -1; rr2 = -1; rl1 = -1; rl2 = -1;
        d1 = 32'h0; d2 = 32'h0; e1 = 1'b0; e2 = 1'b0;
        chk({tag, ".idle"}, {30'b0, rdy2, rdy1}, 32'h3);
        ReqValid = 1'b1; MemWriteM = w; Funct3M = f3; AddrM = a; WriteDataM = wd;
        Flush = (fl_at == 0);
        #1 snap(0);
        for (int c = 1; c < 8; c++) begin
            tick();
            if (rdy1 && rr1 < 0) rr1 = c;
            if (rdy2 && rr2 < 0) rr2 = c;
            if (rv1 && rl1 < 0) begin rl1 = c; d1 = rd1; e1 = re1; end
            if (rv2 && rl2 < 0) begin rl2 = c; d2 = rd2; e2 = re2; end
            ReqValid = 1'b0;
            Flush = (fl_at == c);
            #1 snap(c);
        end
        Flush = 1'b0;
        chk({tag, ".rdy1"}, 32'(rr1), 32'(er1));
        chk({tag, ".rsp1"}, 32'(rl1), ev1 ? 32'(er1) : 32'hFFFF_FFFF);
        chk({tag, ".rdy2"}, 32'(rr2), 32'(er2));
        chk({tag, ".rsp2"}, 32'(rl2), ev2 ? 32'(er2) : 32'hFFFF_FFFF);
        if (ev1) begin
            chk({tag, ".data1"}, d1, ed);
            chk({tag, ".err1"}, {31'b0, e1}, {31'b0, ee});
        end
        if (ev2) begin
            chk({tag, ".data2"}, d2, ed);
            chk({tag, ".err2"}, {31'b0, e2}, {31'b0, ee});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic seen;
        n_chk = 0; n_pass = 0;
        reset = 1'b1; ReqValid = 1'b0; MemWriteM = 1'b0; Funct3M = 3'd0; AddrM = 12'h0;
        WriteDataM = 32'h0; Flush = 1'b0; pl_en = 1'b0; pl_a = 10'h0; pl_d = 32'h0;
        repeat (2) tick();

        // request presented while reset is high must not reach the BRAM
        ReqValid = 1'b1; MemWriteM = 1'b1; Funct3M = F3_W; AddrM = 12'h010; WriteDataM = 32'hCAFE_F00D;
        #1;
        chk("rst.bus1", {17'b0, en1, we1, ba1}, 32'h0);
        chk("rst.wd1", bw1, 32'h0);
        chk("rst.rsp1", {30'b0, rv1, re1}, 32'h0);
        chk("rst.rdata1", rd1, 32'h0);
        ReqValid = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        chk("rst.rdy", {30'b0, rdy2, rdy1}, 32'h3);
        tick();

        // SW then back-to-back LW
        ReqValid = 1'b1; MemWriteM = 1'b1; Funct3M = F3_W; AddrM = 12'h010; WriteDataM = 32'hDEAD_BEEF;
        #1;
        chk("sw.bus", {17'b0, en1, we1, ba1}, 32'h7C04);
        chk("sw.wdata", bw1, 32'hDEAD_BEEF);
        tick();
        chk("sw.rsp_rdy", {30'b0, rv1, rdy1}, 32'h3);
        chk("sw.rdata", rd1, 32'h0);
        MemWriteM = 1'b0;
        #1;
        chk("lw.bus", {17'b0, en1, we1, ba1}, 32'h4004);
        tick();
        ReqValid = 1'b0;
        chk("lw.early", {31'b0, rv1}, 32'h0);
        tick();
        chk("lw.rsp1", {30'b0, rv1, re1}, 32'h2);
        chk("lw.data1", rd1, 32'hDEAD_BEEF);
        tick();
        chk("lw.rsp2", {30'b0, rv2, re2}, 32'h2);
        chk("lw.data2", rd2, 32'hDEAD_BEEF);
        repeat (2) tick();

        // sign/zero extension
        pl(10'd1, 32'h0000_80FF);
        xact("lb",  1'b0, F3_B,  12'h004, 32'h0, -9, 2, 1'b1, 3, 1'b1, 32'hFFFF_FFFF, 1'b0);
        xact("lbu", 1'b0, F3_BU, 12'h004, 32'h0, -9, 2, 1'b1, 3, 1'b1, 32'h0000_00FF, 1'b0);
        xact("lh",  1'b0, F3_H,  12'h004, 32'h0, -9, 2, 1'b1, 3, 1'b1, 32'hFFFF_80FF, 1'b0);
        xact("lhu", 1'b0, F3_HU, 12'h005, 32'h0, -9, 2, 1'b1, 3, 1'b1, 32'h0000_0080, 1'b0);

        // misaligned LW
        pl(10'd0, 32'h4433_2211);
        pl(10'd1, 32'h8877_6655);
        xact("lw_mis", 1'b0, F3_W, 12'h003, 32'h0, -9, 3, 1'b1, 4, 1'b1, 32'h7766_5544, 1'b0);
        chk("lw_mis.lo2", {21'b0, en_log2[0], ad_log2[0]}, 32'h400);
        chk("lw_mis.hi2", {21'b0, en_log2[1], ad_log2[1]}, 32'h401);
        chk("lw_mis.wait2", {31'b0, en_log2[2]}, 32'h0);

        // misaligned SH wrapping from the last word to word 0
        pl(10'd1023, 32'h0);
        pl(10'd0, 32'h0);
        xact("sh_wrap", 1'b1, F3_H, 12'hFFF, 32'h0000_BEEF, -9, 2, 1'b1, 2, 1'b1, 32'h0, 1'b0);
        chk("sh_wrap.lo", {17'b0, en_log1[0], we_log1[0], ad_log1[0]}, 32'h63FF);
        chk("sh_wrap.lo_wd", wd_log1[0], 32'hEF00_0000);
        chk("sh_wrap.hi", {17'b0, en_log1[1], we_log1[1], ad_log1[1]}, 32'h4400);
        chk("sh_wrap.hi_wd", wd_log1[1], 32'h0000_00BE);
        xact("lhu_wrap", 1'b0, F3_HU, 12'hFFF, 32'h0, -9, 3, 1'b1, 4, 1'b1, 32'h0000_BEEF, 1'b0);

        // flush behaviour
        xact("lw_flush", 1'b0, F3_W, 12'h010, 32'h0, 1, 2, 1'b0, 3, 1'b0, 32'h0, 1'b0);
        xact("lw_flush_late", 1'b0, F3_W, 12'h010, 32'h0, 2, 2, 1'b1, 3, 1'b0, 32'hDEAD_BEEF, 1'b0);
        xact("req_flush", 1'b0, F3_W, 12'h010, 32'h0, 0, 1, 1'b0, 1, 1'b0, 32'h0, 1'b0);
        chk("req_flush.noen", {30'b0, en_log2[0], en_log1[0]}, 32'h0);
        pl(10'd8, 32'h0);
        pl(10'd9, 32'h0);
        xact("sw_mis_flush", 1'b1, F3_W, 12'h021, 32'h1234_5678, 1, 2, 1'b1, 2, 1'b1, 32'h0, 1'b0);
        chk("sw_mis_flush.lo", {17'b0, en_log1[0], we_log1[0], ad_log1[0]}, 32'h7808);
        chk("sw_mis_flush.hi", {17'b0, en_log1[1], we_log1[1], ad_log1[1]}, 32'h4409);
        chk("sw_mis_flush.hi_wd", wd_log1[1], 32'h0000_0012);
        xact("lw_mis2", 1'b0, F3_W, 12'h021, 32'h0, -9, 3, 1'b1, 4, 1'b1, 32'h1234_5678, 1'b0);

        // illegal funct3
        xact("ill_ld", 1'b0, 3'b011, 12'h010, 32'h0, -9, 1, 1'b1, 1, 1'b1, 32'h0, 1'b1);
        chk("ill_ld.noen", {30'b0, en_log2[0], en_log1[0]}, 32'h0);
        xact("ill_st", 1'b1, 3'b100, 12'h010, 32'h1111_1111, -9, 1, 1'b1, 1, 1'b1, 32'h0, 1'b1);
        chk("ill_st.noen", {30'b0, en_log2[0], en_log1[0]}, 32'h0);
        xact("lw_after_ill", 1'b0, F3_W, 12'h010, 32'h0, -9, 2, 1'b1, 3, 1'b1, 32'hDEAD_BEEF, 1'b0);

        // reset asserted while the hi write of a misaligned store is on the port
        ReqValid = 1'b1; MemWriteM = 1'b1; Funct3M = F3_W; AddrM = 12'h031; WriteDataM = 32'hA5A5_A5A5;
        #1;
        tick();
        ReqValid = 1'b0;
        #1;
        chk("rst_hi.pre", {30'b0, en2, en1}, 32'h3);
        reset = 1'b1;
        #1;
        chk("rst_hi.bus1", {17'b0, en1, we1, ba1}, 32'h0);
        chk("rst_hi.wd1", bw1, 32'h0);
        chk("rst_hi.bus2", {17'b0, en2, we2, ba2}, 32'h0);
        chk("rst_hi.wd2", bw2, 32'h0);
        tick();
        reset = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (rv1 || rv2) seen = 1'b1;
            tick();
        end
        chk("rst_hi.norsp", {31'b0, seen}, 32'h0);
        chk("rst_hi.rdy", {30'b0, rdy2, rdy1}, 32'h3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
